// File: rtl/flash_emulator.sv
//==============================================================================
// Module   : flash_emulator
// Brief    : Byte-mode parallel NOR flash device model (read-array, read-status,
//            program, block erase) with busy timing on NF_STS.
//            Optional macro FLASH_EMU_WP_PROTECT_EN: NF_WP=0 protects block 0.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module flash_emulator #(
    parameter int ADDR_W       = 8,
    parameter int BLOCK_W      = 4,
    parameter int PROG_CYCLES  = 16,
    parameter int ERASE_CYCLES = 64
) (
    input  logic              CLK_50MHZ,
    input  logic              RST,
    input  logic              NF_CE,
    input  logic              NF_OE,
    input  logic              NF_WE,
    input  logic              NF_RP,
    input  logic              NF_WP,
    input  logic [ADDR_W-1:0] NF_A,
    input  logic [7:0]        NF_D,
    output logic [7:0]        NF_DQ,
    output logic              NF_DQ_OE,
    output logic              NF_STS
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam int CNT_MAX = (PROG_CYCLES > ERASE_CYCLES) ? PROG_CYCLES : ERASE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BLK_W   = ADDR_W - BLOCK_W;
    localparam logic [CNT_W-1:0] PROG_LOAD  = CNT_W'(PROG_CYCLES);
    localparam logic [CNT_W-1:0] ERASE_LOAD = CNT_W'(ERASE_CYCLES);

    // err bit positions: [2]=SR[5] erase error, [1]=SR[4] program error, [0]=SR[1] locked
    localparam int E_ERASE = 2;
    localparam int E_PROG  = 1;
    localparam int E_LOCK  = 0;

    typedef enum logic [2:0] {
        ST_ARRAY       = 3'd0,
        ST_STATUS      = 3'd1,
        ST_PROG_SETUP  = 3'd2,
        ST_ERASE_SETUP = 3'd3,
        ST_PROG_BUSY   = 3'd4,
        ST_ERASE_BUSY  = 3'd5
    } state_t;

    // Input synchroniser stage s1, plus s2 for WE edge detection
    logic              ce_s1_q, oe_s1_q, we_s1_q, rp_s1_q, we_s2_q;
    logic [ADDR_W-1:0] a_s1_q;
    logic [7:0]        d_s1_q;
    logic [ADDR_W-1:0] cap_a_q;
    logic [7:0]        cap_d_q;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BLOCK_W:0]  eoff_q, eoff_d;
    logic [BLK_W-1:0]  blk_q, blk_d;
    logic [ADDR_W-1:0] pa_q, pa_d;
    logic [7:0]        pd_q, pd_d;
    logic [2:0]        err_q, err_d;
    logic [7:0]        dq_q, dq_d;

    logic [7:0]        mem_q [DEPTH] = '{default: 8'hFF};
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [7:0]        mem_wd;

    logic              rst_all;
    logic              commit;
    logic              busy;
    logic              wp_active;
    logic [7:0]        sr;
    logic [7:0]        prog_res;

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            ce_s1_q <= 1'b1;
            oe_s1_q <= 1'b1;
            we_s1_q <= 1'b1;
            rp_s1_q <= 1'b1;
            we_s2_q <= 1'b1;
            a_s1_q  <= '0;
            d_s1_q  <= '0;
            cap_a_q <= '0;
            cap_d_q <= '0;
        end else begin
            ce_s1_q <= NF_CE;
            oe_s1_q <= NF_OE;
            we_s1_q <= NF_WE;
            rp_s1_q <= NF_RP;
            we_s2_q <= we_s1_q;
            a_s1_q  <= NF_A;
            d_s1_q  <= NF_D;
            if (!ce_s1_q && !we_s1_q) begin
                cap_a_q <= a_s1_q;
                cap_d_q <= d_s1_q;
            end
        end
    end

`ifdef FLASH_EMU_WP_PROTECT_EN
    logic wp_s1_q;

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            wp_s1_q <= 1'b1;
        end else begin
            wp_s1_q <= NF_WP;
        end
    end

    assign wp_active = ~wp_s1_q && (cap_a_q[ADDR_W-1:BLOCK_W] == '0);
`else
    logic wp_unused;
    assign wp_unused = NF_WP;
    assign wp_active = 1'b0;
`endif

    assign rst_all  = RST | ~rp_s1_q;
    assign commit   = ~we_s2_q & we_s1_q & ~ce_s1_q;
    assign busy     = (state_q == ST_PROG_BUSY) || (state_q == ST_ERASE_BUSY);
    assign sr       = {~busy, 1'b0, err_q[E_ERASE], err_q[E_PROG], 2'b00, err_q[E_LOCK], 1'b0};
    assign prog_res = mem_q[pa_q] & pd_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        eoff_d  = eoff_q;
        blk_d   = blk_q;
        pa_d    = pa_q;
        pd_d    = pd_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        mem_wa  = pa_q;
        mem_wd  = prog_res;
        dq_d    = (state_q == ST_ARRAY) ? mem_q[a_s1_q] : sr;

        unique case (state_q)
            ST_ARRAY, ST_STATUS: begin
                if (commit) begin
                    case (cap_d_q)
                        8'hFF:        state_d = ST_ARRAY;
                        8'h70:        state_d = ST_STATUS;
                        8'h50:        err_d   = '0;
                        8'h40, 8'h10: state_d = ST_PROG_SETUP;
                        8'h20:        state_d = ST_ERASE_SETUP;
                        default:      ;
                    endcase
                end
            end
            ST_PROG_SETUP: begin
                if (commit) begin
                    pa_d = cap_a_q;
                    pd_d = cap_d_q;
                    if (wp_active) begin
                        err_d[E_LOCK] = 1'b1;
                        err_d[E_PROG] = 1'b1;
                        state_d       = ST_STATUS;
                    end else begin
                        cnt_d   = PROG_LOAD;
                        state_d = ST_PROG_BUSY;
                    end
                end
            end
            ST_ERASE_SETUP: begin
                if (commit) begin
                    if (cap_d_q != 8'hD0) begin
                        err_d[E_ERASE] = 1'b1;
                        err_d[E_PROG]  = 1'b1;
                        state_d        = ST_STATUS;
                    end else if (wp_active) begin
                        err_d[E_LOCK]  = 1'b1;
                        err_d[E_ERASE] = 1'b1;
                        state_d        = ST_STATUS;
                    end else begin
                        blk_d   = cap_a_q[ADDR_W-1:BLOCK_W];
                        eoff_d  = '0;
                        cnt_d   = ERASE_LOAD;
                        state_d = ST_ERASE_BUSY;
                    end
                end
            end
            ST_PROG_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    mem_we = 1'b1;
                    // A 0->1 attempt leaves the AND different from the requested data
                    if (prog_res != pd_q) begin
                        err_d[E_PROG] = 1'b1;
                    end
                    state_d = ST_STATUS;
                end
            end
            ST_ERASE_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (!eoff_q[BLOCK_W]) begin
                    mem_we = 1'b1;
                    mem_wa = {blk_q, eoff_q[BLOCK_W-1:0]};
                    mem_wd = 8'hFF;
                    eoff_d = eoff_q + (BLOCK_W+1)'(1);
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_STATUS;
                end
            end
            default: state_d = ST_ARRAY;
        endcase
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (rst_all) begin
            state_q <= ST_ARRAY;
            cnt_q   <= '0;
            eoff_q  <= '0;
            blk_q   <= '0;
            pa_q    <= '0;
            pd_q    <= '0;
            err_q   <= '0;
            dq_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            eoff_q  <= eoff_d;
            blk_q   <= blk_d;
            pa_q    <= pa_d;
            pd_q    <= pd_d;
            err_q   <= err_d;
            dq_q    <= dq_d;
        end
    end

    // Array is deliberately outside reset; an abort leaves partial erase results
    always_ff @(posedge CLK_50MHZ) begin
        if (mem_we && !rst_all) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    assign NF_DQ    = dq_q;
    assign NF_DQ_OE = ~ce_s1_q & ~oe_s1_q & we_s1_q & rp_s1_q;
    assign NF_STS   = ~busy;

endmodule

`default_nettype wire

// File: tb/tb_flash_emulator.sv
//==============================================================================
// Module   : tb_flash_emulator
// Brief    : Directed, table-driven self-checking bench for flash_emulator.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_flash_emulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       nf_ce, nf_oe, nf_we, nf_rp, nf_wp;
    logic [7:0] nf_a, nf_d;
    logic [7:0] nf_dq;
    logic       nf_dq_oe, nf_sts;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] exp;
    } rd_vec_t;

    rd_vec_t erase_vecs [7];

    always #5 clk = ~clk;

    flash_emulator #(
        .ADDR_W      (8),
        .BLOCK_W     (4),
        .PROG_CYCLES (16),
        .ERASE_CYCLES(64)
    ) dut (
        .CLK_50MHZ(clk),
        .RST      (rst),
        .NF_CE    (nf_ce),
        .NF_OE    (nf_oe),
        .NF_WE    (nf_we),
        .NF_RP    (nf_rp),
        .NF_WP    (nf_wp),
        .NF_A     (nf_a),
        .NF_D     (nf_d),
        .NF_DQ    (nf_dq),
        .NF_DQ_OE (nf_dq_oe),
        .NF_STS   (nf_sts)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns with the write committed and any busy phase already started
    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        nf_a  = a;
        nf_d  = d;
        nf_oe = 1'b1;
        nf_ce = 1'b0;
        nf_we = 1'b0;
        tick();
        tick();
        nf_we = 1'b1;
        tick();
        tick();
        nf_ce = 1'b1;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] dq, output logic oe);
        nf_a  = a;
        nf_we = 1'b1;
        nf_ce = 1'b0;
        nf_oe = 1'b0;
        tick();
        tick();
        dq    = nf_dq;
        oe    = nf_dq_oe;
        nf_ce = 1'b1;
        nf_oe = 1'b1;
        tick();
    endtask

    task automatic wait_ready(input string name, input int exp_cycles);
        int n;
        n = 0;
        while (nf_sts == 1'b0 && n < 1000) begin
            n++;
            tick();
        end
        chk(name, 32'(n), 32'(exp_cycles));
    endtask

    task automatic read_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] dq;
        logic       oe;
        bus_read(a, dq, oe);
        chk(name, {24'h0, dq}, {24'h0, exp});
    endtask

    task automatic program_byte(input string name, input logic [7:0] a, input logic [7:0] d);
        bus_write(8'h00, 8'h40);
        bus_write(a, d);
        wait_ready(name, 16);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] dq;
        logic       oe;

        erase_vecs[0] = '{addr: 8'h10, exp: 8'hFF};
        erase_vecs[1] = '{addr: 8'h13, exp: 8'hFF};
        erase_vecs[2] = '{addr: 8'h15, exp: 8'hFF};
        erase_vecs[3] = '{addr: 8'h1F, exp: 8'hFF};
        erase_vecs[4] = '{addr: 8'h0F, exp: 8'h3C};
        erase_vecs[5] = '{addr: 8'h20, exp: 8'hC3};
        erase_vecs[6] = '{addr: 8'h05, exp: 8'h00};

        rst   = 1'b1;
        nf_ce = 1'b1;
        nf_oe = 1'b1;
        nf_we = 1'b1;
        nf_rp = 1'b1;
        nf_wp = 1'b1;
        nf_a  = 8'h00;
        nf_d  = 8'h00;
        tick();
        tick();
        tick();
        chk("reset_dq", {24'h0, nf_dq}, 32'h00);
        chk("reset_dq_oe", {31'h0, nf_dq_oe}, 32'h0);
        chk("reset_sts", {31'h0, nf_sts}, 32'h1);
        rst = 1'b0;
        tick();

        // First read of erased array
        bus_read(8'h05, dq, oe);
        chk("read0_dq", {24'h0, dq}, 32'hFF);
        chk("read0_dq_oe", {31'h0, oe}, 32'h1);
        chk("read0_sts", {31'h0, nf_sts}, 32'h1);

        // Program A5 at 05
        bus_write(8'h00, 8'h40);
        bus_write(8'h05, 8'hA5);
        wait_ready("prog1_busy_cycles", 16);
        read_chk("prog1_sr", 8'h05, 8'h80);
        bus_write(8'h00, 8'hFF);
        read_chk("prog1_data", 8'h05, 8'hA5);

        // 0->1 attempt: AND stored, program error flagged, 50 clears
        bus_write(8'h00, 8'h10);
        bus_write(8'h05, 8'h5A);
        wait_ready("prog2_busy_cycles", 16);
        read_chk("prog2_sr_err", 8'h05, 8'h90);
        bus_write(8'h00, 8'h50);
        read_chk("prog2_sr_clr", 8'h05, 8'h80);
        bus_write(8'h00, 8'hFF);
        read_chk("prog2_data", 8'h05, 8'h00);

        // Block erase of block 1 with neighbours preset
        program_byte("pre_0f_busy", 8'h0F, 8'h3C);
        program_byte("pre_20_busy", 8'h20, 8'hC3);
        program_byte("pre_15_busy", 8'h15, 8'h00);
        bus_write(8'h00, 8'h20);
        bus_write(8'h13, 8'hD0);
        wait_ready("erase_busy_cycles", 64);
        read_chk("erase_sr", 8'h13, 8'h80);
        bus_write(8'h00, 8'hFF);
        for (int i = 0; i < 7; i++) begin
            bus_read(erase_vecs[i].addr, dq, oe);
            chk($sformatf("erase_vec%0d_a%02h", i, erase_vecs[i].addr),
                {24'h0, dq}, {24'h0, erase_vecs[i].exp});
        end

        // Erase sequence error
        bus_write(8'h00, 8'h20);
        bus_write(8'h05, 8'h40);
        chk("seqerr_sts", {31'h0, nf_sts}, 32'h1);
        read_chk("seqerr_sr", 8'h05, 8'hB0);
        bus_write(8'h00, 8'hFF);
        read_chk("seqerr_data", 8'h05, 8'h00);
        bus_write(8'h00, 8'h50);
        bus_write(8'h00, 8'h70);
        read_chk("seqerr_sr_clr", 8'h05, 8'h80);

        // NF_RP abort during erase of block 3
        program_byte("pre_30_busy", 8'h30, 8'h00);
        program_byte("pre_3f_busy", 8'h3F, 8'h00);
        bus_write(8'h00, 8'h20);
        bus_write(8'h30, 8'hD0);
        bus_read(8'h30, dq, oe);
        chk("abort_busy_sr", {24'h0, dq}, 32'h00);
        chk("abort_busy_sts", {31'h0, nf_sts}, 32'h0);
        nf_rp = 1'b0;
        tick();
        nf_rp = 1'b1;
        tick();
        chk("abort_sts", {31'h0, nf_sts}, 32'h1);
        chk("abort_dq", {24'h0, nf_dq}, 32'h00);
        read_chk("abort_partial_lo", 8'h30, 8'hFF);
        read_chk("abort_partial_hi", 8'h3F, 8'h00);
        bus_write(8'h00, 8'h70);
        read_chk("abort_sr", 8'h30, 8'h80);

        // Write protect of block 0
        nf_wp = 1'b0;
        bus_write(8'h00, 8'h40);
        bus_write(8'h02, 8'h00);
`ifdef FLASH_EMU_WP_PROTECT_EN
        wait_ready("wp_busy_cycles", 0);
        read_chk("wp_sr", 8'h02, 8'h92);
        bus_write(8'h00, 8'hFF);
        read_chk("wp_data", 8'h02, 8'hFF);
`else
        wait_ready("wp_busy_cycles", 16);
        read_chk("wp_sr", 8'h02, 8'h80);
        bus_write(8'h00, 8'hFF);
        read_chk("wp_data", 8'h02, 8'h00);
`endif
        nf_wp = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
